// File: rtl/case_match_seq_pkg.sv
// Shared types and the case-item table for case_match_sequencer.
// The table is walked in index order; the lowest matching index wins.
package case_match_seq_pkg;

  localparam int unsigned CSQ_W      = 4;
  localparam int unsigned CSQ_OW     = 32;
  localparam int unsigned CSQ_NITEMS = 2;

  typedef enum logic [1:0] {
    CSQ_IDLE,
    CSQ_EVAL,
    CSQ_DONE
  } csq_state_e;

  typedef enum logic {
    KIND_POSTINC,
    KIND_CONST
  } csq_kind_e;

  typedef struct packed {
    csq_kind_e           kind;
    logic [CSQ_W-1:0]    value;
    logic [CSQ_OW-1:0]   answer;
  } csq_item_t;

  // item0: case (tmp++) -> 1 ; item1: case (0) -> 2
  localparam csq_item_t CSQ_ITEMS [CSQ_NITEMS] = '{
    '{kind: KIND_POSTINC, value: '0, answer: 32'd1},
    '{kind: KIND_CONST,   value: '0, answer: 32'd2}
  };

endpackage

// File: rtl/case_match_sequencer_item_eval.sv
// Combinational evaluation of a single case item against selector a.
// POSTINC items compare against the pre-increment tmp and advance it.
module csq_item_eval
  import case_match_seq_pkg::*;
#(
  parameter int unsigned W = CSQ_W
) (
  input  csq_item_t      item,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   tmp,
  output logic           hit,
  output logic [W-1:0]   next_tmp
);

  // The answer field is consumed by the sequencer, not here.
  logic unused_answer;
  assign unused_answer = ^item.answer;

  always_comb begin
    hit      = 1'b0;
    next_tmp = tmp;
    if (item.kind == KIND_POSTINC) begin
      hit      = (a == tmp);
      next_tmp = tmp + W'(1);
    end else begin
      hit      = (a == W'(item.value));
    end
  end

endmodule

// File: rtl/case_match_sequencer.sv
// Priority case engine: one item per cycle, stops at first match.
// Optional CASE_MATCH_SEQ_TMP_OUT_EN exposes the final tmp on rsp_tmp.
module case_match_sequencer
  import case_match_seq_pkg::*;
#(
  parameter int unsigned NITEMS = CSQ_NITEMS,
  parameter int unsigned W      = CSQ_W,
  parameter int unsigned OW     = CSQ_OW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [W-1:0]  req_a,
  input  logic [W-1:0]  req_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [OW-1:0] rsp_out,
  output logic          rsp_hit
`ifdef CASE_MATCH_SEQ_TMP_OUT_EN
  ,
  output logic [W-1:0]  rsp_tmp
`endif
);

  localparam int unsigned IW = (NITEMS > 1) ? $clog2(NITEMS) : 1;

  csq_state_e     state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   tmp_q, tmp_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           req_ready_d;
  logic           rsp_valid_d;
  logic [OW-1:0]  rsp_out_d;
  logic           rsp_hit_d;

  csq_item_t      cur_item;
  logic           item_hit;
  logic [W-1:0]   item_next_tmp;

  assign cur_item = CSQ_ITEMS[idx_q];

  csq_item_eval #(
    .W (W)
  ) u_item_eval (
    .item     (cur_item),
    .a        (a_q),
    .tmp      (tmp_q),
    .hit      (item_hit),
    .next_tmp (item_next_tmp)
  );

`ifdef CASE_MATCH_SEQ_TMP_OUT_EN
  // tmp_q already holds the post-evaluation value while in DONE.
  assign rsp_tmp = tmp_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CSQ_IDLE;
      a_q       <= '0;
      tmp_q     <= '0;
      idx_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_hit   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      tmp_q     <= tmp_d;
      idx_q     <= idx_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_out   <= rsp_out_d;
      rsp_hit   <= rsp_hit_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    tmp_d       = tmp_q;
    idx_d       = idx_q;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_out_d   = rsp_out;
    rsp_hit_d   = rsp_hit;

    unique case (state_q)
      CSQ_IDLE: begin
        if (req_valid && req_ready) begin
          a_d         = req_a;
          tmp_d       = req_b;
          idx_d       = '0;
          req_ready_d = 1'b0;
          state_d     = CSQ_EVAL;
        end
      end

      CSQ_EVAL: begin
        // Side effect applies only to items actually evaluated.
        tmp_d = item_next_tmp;
        if (item_hit) begin
          rsp_out_d   = OW'(cur_item.answer);
          rsp_hit_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = CSQ_DONE;
        end else if (idx_q == IW'(NITEMS - 1)) begin
          rsp_out_d   = '0;
          rsp_hit_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = CSQ_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      CSQ_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = CSQ_IDLE;
        end
      end

      default: begin
        state_d     = CSQ_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_case_match_sequencer.sv
// Scoreboard bench for case_match_sequencer: directed requests push expectations,
// a monitor checks each response as rsp_valid rises.
module tb_case_match_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_a;
  logic [3:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_out;
  logic        rsp_hit;
`ifdef CASE_MATCH_SEQ_TMP_OUT_EN
  logic [3:0]  rsp_tmp;
`endif

  case_match_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_hit   (rsp_hit)
`ifdef CASE_MATCH_SEQ_TMP_OUT_EN
    ,
    .rsp_tmp   (rsp_tmp)
`endif
  );

  typedef struct {
    logic [31:0] out;
    logic        hit;
    logic [3:0]  tmp;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic prev_v = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each new response against the oldest expectation.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 out=%0h expected no response", rsp_out);
        end else begin
          exp_t e;
          int   acc;
          e   = exp_q.pop_front();
          acc = (acc_q.size() > 0) ? acc_q.pop_front() : cyc;
          chk("rsp_out", rsp_out, e.out);
          chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
          chk("latency", 32'(cyc - acc + 1), 32'(e.lat));
`ifdef CASE_MATCH_SEQ_TMP_OUT_EN
          chk("rsp_tmp", 32'(rsp_tmp), 32'(e.tmp));
`endif
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic do_req(input logic [3:0] a, input logic [3:0] b, input logic [31:0] eo,
                        input logic eh, input logic [3:0] et, input int el, input bit expect_rsp);
    exp_t e;
    int   n;
    @(negedge clk);
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_accept_timeout: got req_ready=0 expected 1");
    end
    if (expect_rsp) begin
      e.out = eo; e.hit = eh; e.tmp = et; e.lat = el;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
    if (expect_rsp) acc_q.push_back(cyc);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_out", rsp_out, 32'd0);
    chk("reset_rsp_hit", 32'(rsp_hit), 32'd0);
`ifdef CASE_MATCH_SEQ_TMP_OUT_EN
    chk("reset_rsp_tmp", 32'(rsp_tmp), 32'd0);
`endif

    // a, b, out, hit, final tmp, latency
    do_req(4'd5,  4'd5,  32'd1, 1'b1, 4'd6, 2, 1'b1); drain();
    do_req(4'd0,  4'd3,  32'd2, 1'b1, 4'd4, 3, 1'b1); drain();
    do_req(4'd0,  4'd0,  32'd1, 1'b1, 4'd1, 2, 1'b1); drain();
    do_req(4'd7,  4'd3,  32'd0, 1'b0, 4'd4, 3, 1'b1); drain();
    do_req(4'd15, 4'd15, 32'd1, 1'b1, 4'd0, 2, 1'b1); drain();
    do_req(4'd0,  4'd15, 32'd2, 1'b1, 4'd0, 3, 1'b1); drain();
    do_req(4'd3,  4'd2,  32'd0, 1'b0, 4'd3, 3, 1'b1); drain();

    // Backpressure: response must hold, and a second request is refused.
    rsp_ready = 1'b0;
    do_req(4'd5, 4'd5, 32'd1, 1'b1, 4'd6, 2, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_a     = 4'd0;
      req_b     = 4'd3;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_out", rsp_out, 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_req_ready", 32'(req_ready), 32'd1);
    chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
    drain();

    // Reset mid-evaluation drops the request with no response.
    do_req(4'd0, 4'd3, 32'd0, 1'b0, 4'd0, 0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_eval_req_ready", 32'(req_ready), 32'd1);
    chk("rst_eval_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_eval_rsp_out", rsp_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    do_req(4'd0, 4'd3, 32'd2, 1'b1, 4'd4, 3, 1'b1); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
